wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 21 ++
 rtl/wb_load_ext.sv | 32 +++
 rtl/wb_stage.sv | 130 +++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: default widths, RISC-V load
// funct3 encodings and the FSM state encoding.
package wb_stage_pkg;

   localparam int unsigned XLEN_DEF   = 64;
   localparam int unsigned REG_AW_DEF = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_WAIT_RD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational load alignment and sign/zero extension of an aligned
// doubleword response, selected by byte offset and load funct3.
module wb_load_ext
   import wb_stage_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      offset_i,
   input  logic [2:0]      type_i,
   output logic [XLEN-1:0] data_o
);

   logic [XLEN-1:0] shifted;

   // Bring the addressed byte down to bit 0; offsets are used as given.
   assign shifted = data_i >> {offset_i, 3'b000};

   always_comb begin
      data_o = data_i;
      case (type_i)
         F3_LB:   data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LH:   data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         F3_LW:   data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         F3_LWU:  data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
         default: data_o = data_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires non-loads directly, holds loads until the read
// response arrives. Define DIFFTEST_EN to add the retired-PC output pc_wb_o.
//
// state      | meaning
// ST_IDLE    | ready for a MEM transfer; non-loads commit next cycle
// ST_WAIT_RD | load latched, waiting for rdata_valid_i; MEM input stalled
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_valid_i,
   output logic              mem_ready_o,
   input  logic [XLEN-1:0]   mem_pc_i,
   input  logic [REG_AW-1:0] mem_rd_addr_i,
   input  logic              mem_rd_wen_i,
   input  logic [XLEN-1:0]   mem_alu_res_i,
   input  logic              mem_is_load_i,
   input  logic [2:0]        mem_load_type_i,
   input  logic              rdata_valid_i,
   input  logic [XLEN-1:0]   rdata_i,
   output logic              wr_en_o,
   output logic [REG_AW-1:0] wr_addr_o,
   output logic [XLEN-1:0]   wr_data_o,
   output logic              commit_o
`ifdef DIFFTEST_EN
   ,
   output logic [XLEN-1:0]   pc_wb_o
`endif
);

   wb_state_e         state_q;
   logic              wr_en_q;
   logic              commit_q;
   logic [REG_AW-1:0] wr_addr_q;
   logic [XLEN-1:0]   wr_data_q;
   logic [REG_AW-1:0] rd_p_q;
   logic              wen_p_q;
   logic [2:0]        type_p_q;
   logic [2:0]        off_p_q;
   logic [XLEN-1:0]   ld_data;

`ifdef DIFFTEST_EN
   logic [XLEN-1:0]   pc_p_q;
   logic [XLEN-1:0]   pc_wb_q;
   assign pc_wb_o = pc_wb_q;
`else
   logic unused_pc;
   assign unused_pc = ^mem_pc_i;
`endif

   wb_load_ext #(.XLEN(XLEN)) u_load_ext (
      .data_i   (rdata_i),
      .offset_i (off_p_q),
      .type_i   (type_p_q),
      .data_o   (ld_data)
   );

   assign mem_ready_o = (state_q == ST_IDLE);
   assign wr_en_o     = wr_en_q;
   assign commit_o    = commit_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_data_o   = wr_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wr_en_q   <= 1'b0;
         commit_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_p_q    <= '0;
         wen_p_q   <= 1'b0;
         type_p_q  <= '0;
         off_p_q   <= '0;
`ifdef DIFFTEST_EN
         pc_p_q    <= '0;
         pc_wb_q   <= '0;
`endif
      end else begin
         // Retire outputs are single-cycle pulses unless re-armed below.
         wr_en_q  <= 1'b0;
         commit_q <= 1'b0;
`ifdef DIFFTEST_EN
         pc_wb_q  <= '0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (mem_valid_i) begin
                  if (!mem_is_load_i) begin
                     commit_q  <= 1'b1;
                     wr_en_q   <= mem_rd_wen_i && (mem_rd_addr_i != '0);
                     wr_addr_q <= mem_rd_addr_i;
                     wr_data_q <= mem_alu_res_i;
`ifdef DIFFTEST_EN
                     pc_wb_q   <= mem_pc_i;
`endif
                  end else begin
                     rd_p_q   <= mem_rd_addr_i;
                     wen_p_q  <= mem_rd_wen_i;
                     type_p_q <= mem_load_type_i;
                     off_p_q  <= mem_alu_res_i[2:0];
`ifdef DIFFTEST_EN
                     pc_p_q   <= mem_pc_i;
`endif
                     state_q  <= ST_WAIT_RD;
                  end
               end
            end
            ST_WAIT_RD: begin
               if (rdata_valid_i) begin
                  commit_q  <= 1'b1;
                  wr_en_q   <= wen_p_q && (rd_p_q != '0);
                  wr_addr_q <= rd_p_q;
                  wr_data_q <= ld_data;
`ifdef DIFFTEST_EN
                  pc_wb_q   <= pc_p_q;
`endif
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed instructions push expected retires,
// a negedge monitor pops and compares on every commit_o pulse.
module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid_i;
   logic        mem_ready_o;
   logic [63:0] mem_pc_i;
   logic [4:0]  mem_rd_addr_i;
   logic        mem_rd_wen_i;
   logic [63:0] mem_alu_res_i;
   logic        mem_is_load_i;
   logic [2:0]  mem_load_type_i;
   logic        rdata_valid_i;
   logic [63:0] rdata_i;
   logic        wr_en_o;
   logic [4:0]  wr_addr_o;
   logic [63:0] wr_data_o;
   logic        commit_o;
`ifdef DIFFTEST_EN
   logic [63:0] pc_wb_o;
`endif

   typedef struct {
      logic        wen;
      logic [4:0]  addr;
      logic [63:0] data;
      logic [63:0] pc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   wb_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .mem_valid_i     (mem_valid_i),
      .mem_ready_o     (mem_ready_o),
      .mem_pc_i        (mem_pc_i),
      .mem_rd_addr_i   (mem_rd_addr_i),
      .mem_rd_wen_i    (mem_rd_wen_i),
      .mem_alu_res_i   (mem_alu_res_i),
      .mem_is_load_i   (mem_is_load_i),
      .mem_load_type_i (mem_load_type_i),
      .rdata_valid_i   (rdata_valid_i),
      .rdata_i         (rdata_i),
      .wr_en_o         (wr_en_o),
      .wr_addr_o       (wr_addr_o),
      .wr_data_o       (wr_data_o),
      .commit_o        (commit_o)
`ifdef DIFFTEST_EN
      ,
      .pc_wb_o         (pc_wb_o)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic wen, input logic [4:0] rd, input logic [63:0] data,
                       input logic [63:0] pc);
      exp_t e;
      e.wen  = wen && (rd != 5'd0);
      e.addr = rd;
      e.data = data;
      e.pc   = pc;
      sb.push_back(e);
   endtask

   task automatic drive_idle();
      mem_valid_i     = 1'b0;
      mem_is_load_i   = 1'b0;
      mem_pc_i        = '0;
      mem_rd_addr_i   = '0;
      mem_rd_wen_i    = 1'b0;
      mem_alu_res_i   = '0;
      mem_load_type_i = '0;
   endtask

   task automatic drive_op(input logic ld, input logic [2:0] ft, input logic [4:0] rd,
                           input logic wen, input logic [63:0] alu, input logic [63:0] pc);
      mem_valid_i     = 1'b1;
      mem_is_load_i   = ld;
      mem_load_type_i = ft;
      mem_rd_addr_i   = rd;
      mem_rd_wen_i    = wen;
      mem_alu_res_i   = alu;
      mem_pc_i        = pc;
   endtask

   task automatic do_alu(input logic [4:0] rd, input logic wen, input logic [63:0] res,
                         input logic [63:0] pc);
      @(negedge clk);
      drive_op(1'b0, 3'b000, rd, wen, res, pc);
      push(wen, rd, res, pc);
      @(negedge clk);
      drive_idle();
   endtask

   // While waiting, a bogus non-load is held valid; the stage must ignore it.
   task automatic do_load(input logic [2:0] ft, input logic [4:0] rd, input logic wen,
                          input logic [63:0] alu, input logic [63:0] pc,
                          input logic [63:0] rdata, input logic [63:0] exp_data,
                          input int nwait);
      @(negedge clk);
      drive_op(1'b1, ft, rd, wen, alu, pc);
      for (int i = 0; i < nwait; i++) begin
         @(negedge clk);
         chk("ready_low_wait", {63'd0, mem_ready_o}, 64'd0);
         drive_op(1'b0, 3'b000, 5'd20, 1'b1, 64'hDEAD, 64'h9999);
      end
      @(negedge clk);
      drive_idle();
      rdata_valid_i = 1'b1;
      rdata_i       = rdata;
      push(wen, rd, exp_data, pc);
      @(negedge clk);
      rdata_valid_i = 1'b0;
      rdata_i       = 64'hBAD0_BAD0_BAD0_BAD0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (commit_o) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_commit actual=commit expected=none addr=%0d", wr_addr_o);
            end else begin
               e = sb.pop_front();
               chk("wr_en", {63'd0, wr_en_o}, {63'd0, e.wen});
               if (e.wen) begin
                  chk("wr_addr", {59'd0, wr_addr_o}, {59'd0, e.addr});
                  chk("wr_data", wr_data_o, e.data);
               end
`ifdef DIFFTEST_EN
               chk("pc_wb", pc_wb_o, e.pc);
`endif
            end
         end else begin
            chk("no_wr_without_commit", {63'd0, wr_en_o}, 64'd0);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "testbench timeout");
   end

   initial begin : stimulus
      rst_n         = 1'b0;
      rdata_valid_i = 1'b0;
      rdata_i       = '0;
      drive_idle();
      repeat (2) @(negedge clk);
      chk("rst_wr_en", {63'd0, wr_en_o}, 64'd0);
      chk("rst_commit", {63'd0, commit_o}, 64'd0);
      chk("rst_wr_addr", {59'd0, wr_addr_o}, 64'd0);
      chk("rst_wr_data", wr_data_o, 64'd0);
      chk("rst_ready", {63'd0, mem_ready_o}, 64'd1);
      rst_n = 1'b1;

      // First transfer on the first edge after reset release.
      drive_op(1'b0, 3'b000, 5'd5, 1'b1, 64'h1234, 64'h8000_0000);
      push(1'b1, 5'd5, 64'h1234, 64'h8000_0000);
      @(negedge clk);
      drive_idle();

      do_alu(5'd0, 1'b1, 64'h55, 64'h8000_0004);

      // rdata_valid_i in IDLE must not produce a commit.
      @(negedge clk);
      rdata_valid_i = 1'b1;
      rdata_i       = 64'h1111;
      @(negedge clk);
      rdata_valid_i = 1'b0;

      do_load(F3_LB,  5'd6,  1'b1, 64'h8000_1003, 64'h8000_0008,
              64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 3);
      do_load(F3_LWU, 5'd7,  1'b1, 64'h8000_1004, 64'h8000_000C,
              64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF, 1);
      do_load(F3_LH,  5'd8,  1'b1, 64'h8000_1002, 64'h8000_0010,
              64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_80FF, 0);
      do_load(F3_LHU, 5'd9,  1'b1, 64'h8000_1006, 64'h8000_0014,
              64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_1234, 2);
      do_load(F3_LW,  5'd10, 1'b1, 64'h8000_1000, 64'h8000_0018,
              64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0001, 1);
      do_load(F3_LW,  5'd14, 1'b1, 64'h8000_1004, 64'h8000_001C,
              64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 1);
      do_load(F3_LBU, 5'd11, 1'b1, 64'h8000_1007, 64'h8000_0020,
              64'hA500_0000_0000_0000, 64'h0000_0000_0000_00A5, 0);
      do_load(F3_LB,  5'd15, 1'b1, 64'h8000_1000, 64'h8000_0024,
              64'hFFFF_FFFF_FFFF_FF7F, 64'h0000_0000_0000_007F, 1);
      do_load(F3_LD,  5'd12, 1'b1, 64'h8000_1000, 64'h8000_0028,
              64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1);
      do_load(F3_LB,  5'd13, 1'b0, 64'h8000_1001, 64'h8000_002C,
              64'h0000_0000_0000_4400, 64'h0000_0000_0000_0044, 1);

      // Four back-to-back non-loads with valid held high.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i > 0) chk("burst_wr_en", {63'd0, wr_en_o}, 64'd1);
         chk("burst_ready", {63'd0, mem_ready_o}, 64'd1);
         drive_op(1'b0, 3'b000, 5'(16 + i), 1'b1, 64'hA0 + 64'(i), 64'h8000_0100 + 64'(4 * i));
         push(1'b1, 5'(16 + i), 64'hA0 + 64'(i), 64'h8000_0100 + 64'(4 * i));
      end
      @(negedge clk);
      chk("burst_wr_en", {63'd0, wr_en_o}, 64'd1);
      drive_idle();

      // Reset while a load is pending discards it.
      @(negedge clk);
      drive_op(1'b1, F3_LD, 5'd21, 1'b1, 64'h8000_2000, 64'h8000_0200);
      @(negedge clk);
      drive_idle();
      chk("wait_ready_low", {63'd0, mem_ready_o}, 64'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_ready", {63'd0, mem_ready_o}, 64'd1);
      chk("rst_mid_wr_data", wr_data_o, 64'd0);
      chk("rst_mid_wr_addr", {59'd0, wr_addr_o}, 64'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      rdata_valid_i = 1'b1;
      rdata_i       = 64'hFEED_FACE_CAFE_BEEF;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_wr_en", {63'd0, wr_en_o}, 64'd0);
         chk("post_rst_ready", {63'd0, mem_ready_o}, 64'd1);
      end
      rdata_valid_i = 1'b0;

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
